// File: rtl/oup_ulpi_regaccess.sv
// ULPI register-access engine.
// Turns one register read or write request into a ULPI TX CMD REGW/REGR
// bus sequence and returns a single-cycle response. Only immediate
// addresses are supported; the extended-register escape is refused.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; bus released
// S_W_CMD   | driving REGW command {2'b10,addr} until PHY takes it (nxt)
// S_W_DATA  | driving write data until PHY takes it (nxt)
// S_W_STP   | one-cycle stp pulse with data 8'h00
// S_R_CMD   | driving REGR command {2'b11,addr} until PHY takes it (nxt)
// S_R_TURN1 | turnaround; PHY must take the bus (dir=1)
// S_R_DATA  | PHY presents register data (nxt=0), or RX CMD abort (nxt=1)
// S_R_TURN2 | waiting for PHY to hand the bus back (dir=0)
// S_ABORT   | bus lost to the PHY; wait for dir=0, then report error
// S_DONE    | one-cycle response pulse
module oup_ulpi_regaccess #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp
);

    localparam logic [5:0]  ADDR_EXT = 6'h2F;
    localparam logic [15:0] TMO      = 16'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_CMD,
        S_W_DATA,
        S_W_STP,
        S_R_CMD,
        S_R_TURN1,
        S_R_DATA,
        S_R_TURN2,
        S_ABORT,
        S_DONE
    } state_t;

    state_t      state_q, state_nx;
    logic        dir_q;
    logic        wr_q, wr_nx;
    logic [5:0]  addr_q, addr_nx;
    logic [7:0]  wdata_q, wdata_nx;
    logic [7:0]  rdata_q, rdata_nx;
    logic        err_q, err_nx;
    logic [15:0] cnt_q, cnt_nx, cnt_inc;
    logic        tmo_hit;
    logic        accept;
    logic        drive_q, drive_nx;
    logic [7:0]  data_nx;
    logic        stp_nx;
    logic        rsp_valid_nx;
    logic        rsp_err_nx;
    logic [7:0]  rsp_rdata_nx;

    // States in which the engine waits on nxt and the timeout runs.
    function automatic logic is_wait(input state_t s);
        return (s == S_W_CMD) || (s == S_W_DATA) || (s == S_R_CMD);
    endfunction

    // Accept only after dir has been low for a full cycle, so a request never
    // starts driving in the turnaround cycle right after the PHY releases.
    assign req_ready = (state_q == S_IDLE) && !ulpi_dir && !dir_q;
    assign accept    = req_valid && req_ready;

    assign cnt_inc = cnt_q + 16'd1;
    assign tmo_hit = !ulpi_nxt && (cnt_inc >= TMO);

    // Output enable drops in the same cycle the PHY claims the bus.
    assign ulpi_data_oe = drive_q && !ulpi_dir;

    // Next-state, request capture and next values of the registered outputs.
    always_comb begin
        state_nx = state_q;
        wr_nx    = wr_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        rdata_nx = rdata_q;
        err_nx   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_nx    = req_write;
                    addr_nx  = req_addr;
                    wdata_nx = req_wdata;
                    rdata_nx = 8'h00;
                    err_nx   = 1'b0;
                    if (req_addr == ADDR_EXT) begin
                        err_nx   = 1'b1;
                        state_nx = S_DONE;
                    end else if (req_write) begin
                        state_nx = S_W_CMD;
                    end else begin
                        state_nx = S_R_CMD;
                    end
                end
            end
            S_W_CMD: begin
                if (ulpi_dir) begin
                    state_nx = S_ABORT;
                end else if (ulpi_nxt) begin
                    state_nx = S_W_DATA;
                end else if (tmo_hit) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_W_DATA: begin
                if (ulpi_dir) begin
                    state_nx = S_ABORT;
                end else if (ulpi_nxt) begin
                    state_nx = S_W_STP;
                end else if (tmo_hit) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_W_STP: begin
                state_nx = S_DONE;
            end
            S_R_CMD: begin
                if (ulpi_dir) begin
                    state_nx = S_ABORT;
                end else if (ulpi_nxt) begin
                    state_nx = S_R_TURN1;
                end else if (tmo_hit) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_R_TURN1: begin
                if (ulpi_dir) begin
                    state_nx = S_R_DATA;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_R_DATA: begin
                if (!ulpi_dir) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end else if (ulpi_nxt) begin
                    state_nx = S_ABORT;
                end else begin
                    rdata_nx = ulpi_data_i;
                    state_nx = S_R_TURN2;
                end
            end
            S_R_TURN2: begin
                if (!ulpi_dir) begin
                    state_nx = S_DONE;
                end
            end
            S_ABORT: begin
                if (!ulpi_dir) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered, so they line up
        // with the state register on the next cycle.
        drive_nx = (state_nx == S_W_CMD) || (state_nx == S_W_DATA) ||
                   (state_nx == S_W_STP) || (state_nx == S_R_CMD);

        data_nx = 8'h00;
        case (state_nx)
            S_W_CMD:  data_nx = {2'b10, addr_nx};
            S_W_DATA: data_nx = wdata_nx;
            S_R_CMD:  data_nx = {2'b11, addr_nx};
            default:  data_nx = 8'h00;
        endcase

        stp_nx       = (state_nx == S_W_STP);
        rsp_valid_nx = (state_nx == S_DONE);
        rsp_err_nx   = (state_nx == S_DONE) && err_nx;
        rsp_rdata_nx = ((state_nx == S_DONE) && !err_nx && !wr_nx) ? rdata_nx : 8'h00;

        cnt_nx = cnt_q;
        if (is_wait(state_nx) && (state_nx != state_q)) begin
            cnt_nx = 16'd0;
        end else if (is_wait(state_q) && !ulpi_nxt) begin
            cnt_nx = cnt_inc;
        end
    end

    // State, captured request/response context and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b1;
            wr_q        <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
            drive_q     <= 1'b0;
            ulpi_data_o <= 8'h00;
            ulpi_stp    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= 8'h00;
        end else begin
            state_q     <= state_nx;
            dir_q       <= ulpi_dir;
            wr_q        <= wr_nx;
            addr_q      <= addr_nx;
            wdata_q     <= wdata_nx;
            rdata_q     <= rdata_nx;
            err_q       <= err_nx;
            cnt_q       <= cnt_nx;
            drive_q     <= drive_nx;
            ulpi_data_o <= data_nx;
            ulpi_stp    <= stp_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_err     <= rsp_err_nx;
            rsp_rdata   <= rsp_rdata_nx;
        end
    end

endmodule

// File: tb/tb_oup_ulpi_regaccess.sv
// Bench for oup_ulpi_regaccess: directed requests with a scripted PHY;
// expected responses go into a scoreboard that a monitor drains.
module tb_oup_ulpi_regaccess;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       ulpi_dir, ulpi_nxt;
    logic [7:0] ulpi_data_i, ulpi_data_o;
    logic       ulpi_data_oe, ulpi_stp;

    oup_ulpi_regaccess #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_i(ulpi_data_i),
        .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int next_id = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
        int         id;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor, sampling mid-cycle away from both edges.
    always begin
        @(negedge clk);
        #2;
        if (!rst && ulpi_dir) chk("oe_while_dir", 32'(ulpi_data_oe), 32'd0);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rsp%0d_rdata", e.id), 32'(rsp_rdata), 32'(e.rdata));
                chk($sformatf("rsp%0d_err", e.id), 32'(rsp_err), 32'(e.err));
                chk($sformatf("rsp%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Present a request from mid-cycle, wait (bounded) for acceptance and
    // record the expected response at handshake cycle + lat.
    task automatic issue(input logic wr, input logic [5:0] a, input logic [7:0] wd,
                         input logic [7:0] er, input logic ee, input int lat,
                         input bit expect_rsp, output int c0);
        int g = 0;
        exp_t t;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        #1;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk($sformatf("accept%0d", next_id), 32'(req_ready), 32'd1);
        c0 = cyc;
        if (expect_rsp) begin
            t.rdata = er;
            t.err   = ee;
            t.cyc   = c0 + lat;
            t.id    = next_id;
            sb.push_back(t);
        end
        next_id++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Advance to the next cycle and apply the PHY side for that cycle.
    task automatic phy(input logic d, input logic n, input logic [7:0] di);
        @(negedge clk);
        ulpi_dir    = d;
        ulpi_nxt    = n;
        ulpi_data_i = di;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int g;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data_o", 32'(ulpi_data_o), 32'd0);
        chk("rst_oe", 32'(ulpi_data_oe), 32'd0);
        chk("rst_stp", 32'(ulpi_stp), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write SCRATCH = A5, nxt=1 throughout.
        ulpi_nxt = 1'b1;
        issue(1'b1, 6'h16, 8'hA5, 8'h00, 1'b0, 4, 1'b1, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("w1_cmd", 32'(ulpi_data_o), 32'h96);
        chk("w1_cmd_oe", 32'(ulpi_data_oe), 32'd1);
        chk("w1_cmd_stp", 32'(ulpi_stp), 32'd0);
        phy(1'b0, 1'b1, 8'h00);
        chk("w1_data", 32'(ulpi_data_o), 32'hA5);
        chk("w1_data_oe", 32'(ulpi_data_oe), 32'd1);
        phy(1'b0, 1'b1, 8'h00);
        chk("w1_stp", 32'(ulpi_stp), 32'd1);
        chk("w1_stp_data", 32'(ulpi_data_o), 32'h00);
        phy(1'b0, 1'b0, 8'h00);
        chk("w1_done_stp", 32'(ulpi_stp), 32'd0);
        chk("w1_done_oe", 32'(ulpi_data_oe), 32'd0);

        // Read VID_L: PHY returns 24.
        @(negedge clk);
        issue(1'b0, 6'h00, 8'h00, 8'h24, 1'b0, 5, 1'b1, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("r1_cmd", 32'(ulpi_data_o), 32'hC0);
        chk("r1_cmd_oe", 32'(ulpi_data_oe), 32'd1);
        phy(1'b1, 1'b0, 8'h00);
        phy(1'b1, 1'b0, 8'h24);
        phy(1'b0, 1'b0, 8'h00);
        phy(1'b0, 1'b0, 8'h00);

        // Write with nxt low for 3 cycles in the command phase.
        @(negedge clk);
        issue(1'b1, 6'h0A, 8'h5A, 8'h00, 1'b0, 7, 1'b1, c0);
        for (int i = 0; i < 3; i++) begin
            phy(1'b0, 1'b0, 8'h00);
            chk($sformatf("w2_hold%0d", i), 32'(ulpi_data_o), 32'h8A);
        end
        phy(1'b0, 1'b1, 8'h00);
        chk("w2_hold3", 32'(ulpi_data_o), 32'h8A);
        phy(1'b0, 1'b1, 8'h00);
        chk("w2_data", 32'(ulpi_data_o), 32'h5A);
        phy(1'b0, 1'b0, 8'h00);
        chk("w2_stp", 32'(ulpi_stp), 32'd1);
        phy(1'b0, 1'b0, 8'h00);

        // dir rises during write data: abort, error, no stp.
        @(negedge clk);
        issue(1'b1, 6'h04, 8'h45, 8'h00, 1'b1, 6, 1'b1, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("w3_cmd", 32'(ulpi_data_o), 32'h84);
        phy(1'b1, 1'b0, 8'h00);
        chk("w3_oe_drop", 32'(ulpi_data_oe), 32'd0);
        for (int i = 0; i < 3; i++) begin
            phy((i < 2) ? 1'b1 : 1'b0, 1'b0, 8'h00);
            chk($sformatf("w3_no_stp%0d", i), 32'(ulpi_stp), 32'd0);
        end
        chk("w3_abort_data", 32'(ulpi_data_o), 32'h00);
        phy(1'b0, 1'b0, 8'h00);
        chk("w3_done_stp", 32'(ulpi_stp), 32'd0);

        // Read with nxt during the data cycle (RX CMD): error.
        @(negedge clk);
        issue(1'b0, 6'h01, 8'h00, 8'h00, 1'b1, 6, 1'b1, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("r2_cmd", 32'(ulpi_data_o), 32'hC1);
        phy(1'b1, 1'b0, 8'h00);
        phy(1'b1, 1'b1, 8'hFF);
        phy(1'b1, 1'b0, 8'h00);
        phy(1'b0, 1'b0, 8'h00);
        phy(1'b0, 1'b0, 8'h00);

        // Extended-register escape address is refused without bus activity.
        @(negedge clk);
        issue(1'b1, 6'h2F, 8'h11, 8'h00, 1'b1, 1, 1'b1, c0);
        phy(1'b0, 1'b0, 8'h00);
        chk("x1_oe", 32'(ulpi_data_oe), 32'd0);
        chk("x1_data", 32'(ulpi_data_o), 32'h00);
        @(negedge clk);
        issue(1'b0, 6'h2F, 8'h00, 8'h00, 1'b1, 1, 1'b1, c0);
        phy(1'b0, 1'b0, 8'h00);
        chk("x2_oe", 32'(ulpi_data_oe), 32'd0);

        // nxt never asserted: timeout after 64 command cycles.
        @(negedge clk);
        issue(1'b1, 6'h16, 8'h33, 8'h00, 1'b1, 65, 1'b1, c0);
        for (int i = 0; i < 64; i++) phy(1'b0, 1'b0, 8'h00);
        chk("t1_still_cmd", 32'(ulpi_data_o), 32'h96);
        phy(1'b0, 1'b0, 8'h00);
        chk("t1_oe_released", 32'(ulpi_data_oe), 32'd0);

        // Reset while the command is being driven: outputs drop at once.
        @(negedge clk);
        issue(1'b1, 6'h16, 8'h77, 8'h00, 1'b0, 4, 1'b0, c0);
        phy(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        chk("rw_data_o", 32'(ulpi_data_o), 32'd0);
        chk("rw_oe", 32'(ulpi_data_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the read data cycle: no response, then recovery.
        issue(1'b0, 6'h02, 8'h00, 8'h00, 1'b0, 5, 1'b0, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("r3_cmd", 32'(ulpi_data_o), 32'hC2);
        phy(1'b1, 1'b0, 8'h00);
        phy(1'b1, 1'b0, 8'h77);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_data_o", 32'(ulpi_data_o), 32'd0);
        chk("rr_oe", 32'(ulpi_data_oe), 32'd0);
        chk("rr_stp", 32'(ulpi_stp), 32'd0);
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rr_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rr_rsp_err", 32'(rsp_err), 32'd0);
        chk("rr_ready", 32'(req_ready), 32'd0);
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready0", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rel_ready1", 32'(req_ready), 32'd1);
        ulpi_nxt = 1'b1;
        issue(1'b1, 6'h16, 8'h3C, 8'h00, 1'b0, 4, 1'b1, c0);
        phy(1'b0, 1'b1, 8'h00);
        chk("w4_cmd", 32'(ulpi_data_o), 32'h96);
        phy(1'b0, 1'b1, 8'h00);
        chk("w4_data", 32'(ulpi_data_o), 32'h3C);
        phy(1'b0, 1'b0, 8'h00);
        phy(1'b0, 1'b0, 8'h00);

        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oup_ulpi_regaccess.md
Name: oup_ulpi_regaccess

Overview:
- ULPI register-access engine: turns single register read/write requests into ULPI TX CMD REGW/REGR bus sequences.
- Sits between the link's register/configuration logic, which issues requests using the oup_ulpi_phyregisters address map, and the ULPI pad interface.
- Immediate addresses (6-bit) only; extended-register escape 6'h2F is rejected.
- One request in flight; the response is a single-cycle pulse.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent waiting for nxt in any command/data state before aborting with an error; 16-bit counter, value must be ≥ 2.

Ports:
- clk  input  1  ULPI 60 MHz clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  engine can accept a request this cycle.
- req_write  input  1  1 = register write, 0 = register read.
- req_addr  input  6  PHY register address (phy_registers_t value).
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  8  read data; valid with rsp_valid, 0 for writes and errors.
- rsp_err  output  1  with rsp_valid: illegal address, bus abort or timeout.
- ulpi_dir  input  1  PHY owns the bus when 1.
- ulpi_nxt  input  1  PHY throttle/next.
- ulpi_data_i  input  8  data from PHY.
- ulpi_data_o  output  8  data to PHY.
- ulpi_data_oe  output  1  link drives data; combinationally forced to 0 whenever ulpi_dir=1.
- ulpi_stp  output  1  link stop.

Behaviour:
- Reset (async, active-high): state IDLE; req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, rsp_err=0, ulpi_data_o=0, internal drive=0, ulpi_stp=0, timeout counter=0. Reset mid-sequence abandons it with no response.
- IDLE:
  - req_ready = (ulpi_dir==0) and dir was 0 last cycle (turnaround guard).
  - Handshake req_valid&req_ready latches write, addr and wdata.
  - If addr==6'h2F: go to DONE with err=1; no bus activity.
- Write path:
  - W_CMD: drive {2'b10,addr} until nxt sampled 1 → W_DATA.
  - W_DATA: drive wdata until nxt sampled 1 → W_STP.
  - W_STP: ulpi_stp=1, data_o=8'h00, driven for exactly one cycle → DONE with err=0.
- Read path:
  - R_CMD: drive {2'b11,addr} until nxt sampled 1 → R_TURN1.
  - R_TURN1: drive=0. If dir sampled 1 → R_DATA; else → DONE with err=1.
  - R_DATA: if dir=1 and nxt=0, capture ulpi_data_i → R_TURN2. If nxt=1, it is an RX CMD abort → ABORT. If dir=0 → DONE with err=1.
  - R_TURN2: wait for dir=0 → DONE with err=0.
- Abort:
  - Bus loss: dir sampled 1 in W_CMD, W_DATA or R_CMD → ABORT; drive=0.
  - ABORT waits until dir sampled 0 → DONE with err=1.
  - No automatic retry; the requester reissues.
- Timeout: counter clears on entering each of W_CMD, W_DATA and R_CMD, and increments each cycle nxt=0. Reaching TIMEOUT_CYCLES → drive=0 → DONE with err=1.
- DONE: exactly one cycle. rsp_valid=1, rsp_rdata = captured data (0 if write or err), rsp_err as set → IDLE. req_ready=0 in DONE.
- Outputs (all registered except ulpi_data_oe):
  - ulpi_data_oe = drive & ~ulpi_dir, combinational.
  - ulpi_data_o = 0 whenever drive=0.
- Latency: back-to-back write with nxt=1 every cycle is handshake + W_CMD + W_DATA + W_STP + DONE (rsp 4 cycles after accept). Read with nxt=1 in R_CMD and immediate dir is rsp 5 cycles after accept.

Test Plan:
- Write SCRATCH (6'h16) = 8'hA5, nxt=1 on both drive cycles → data_o 8'h96 then 8'hA5; stp=1 with data 0 for one cycle; rsp_valid 4 cycles after accept, err=0.
- Read VID_L (6'h00): nxt=1 on 8'hC0; PHY raises dir next cycle, then drives 8'h24 with nxt=0 → rsp_rdata=8'h24, err=0, oe never 1 while dir=1.
- Write with nxt held 0 for 3 cycles in W_CMD → command held stable 4 cycles, then completes normally.
- dir rises during W_DATA → oe drops the same cycle, ABORT until dir falls, then rsp err=1 with no stp pulse. Read with nxt=1 in R_DATA → err=1.
- req_addr=6'h2F → rsp err=1 the cycle after accept, no bus drive. nxt never asserted → err=1 after 64 cycles.
- Assert rst during R_DATA → all outputs 0 asynchronously; no rsp; after release with dir=0, req_ready=1 after one cycle and the next request completes.
